// File: rtl/atarist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : atarist_pkg
//  Description : Shared definitions for the video-port slot arbiter: address
//                width, the bus slot reserved for video reads, the arbiter
//                FSM encoding and the requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package atarist_pkg;

  // Word address width of the RAM video port.
  localparam int ADDR_W = 23;

  // Bus slot (0..3) that carries video-port reads.
  localparam logic [1:0] VIDEO_SLOT = 2'd2;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_t;

  // Identity of the requester holding the current grant.
  typedef enum logic [1:0] {
    GNT_VIK = 2'd0,
    GNT_SHF = 2'd1,
    GNT_DMA = 2'd2
  } arb_who_t;

endpackage
`default_nettype wire

// File: rtl/video_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : video_slot_arbiter
//  Description : Arbitrates the video slot (slot 2 of a 4-slot 8 MHz bus frame)
//                between the display requester (Viking or shifter, chosen by
//                viking_en) and DMA. Display has priority, but DMA is forced a
//                grant once it has lost MAX_STARVE consecutive evaluations.
//
//  Ports       : pclk, reset      - clock, asynchronous active-high reset
//                clk_8_en         - one-pclk 8 MHz bus strobe
//                bus_cycle        - current bus slot (0..3)
//                vik_req/addr     - Viking read request / word address
//                shf_req/addr     - shifter read request / word address
//                dma_req/addr     - DMA read request / word address
//                viking_en        - 1: Viking owns display, 0: shifter
//                ram_addr/read    - RAM video-port address and read strobe
//                ram_data         - RAM read data (valid at end of slot 2)
//                rdata            - registered read data
//                vik/shf/dma_ack  - one-pclk pulse, rdata valid for requester
//  Revision    : 1.0 - initial release
// ============================================================================
module video_slot_arbiter
  import atarist_pkg::*;
#(
  parameter int MAX_STARVE = 8
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              clk_8_en,
  output logic [1:0]        bus_cycle,
  input  logic              vik_req,
  input  logic [ADDR_W-1:0] vik_addr,
  input  logic              shf_req,
  input  logic [ADDR_W-1:0] shf_addr,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              viking_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  input  logic [63:0]       ram_data,
  output logic [63:0]       rdata,
  output logic              vik_ack,
  output logic              shf_ack,
  output logic              dma_ack
);

  localparam logic [3:0] c_max_starve = 4'(MAX_STARVE);
  // Evaluation happens on the strobe that leaves the slot before the video slot.
  localparam logic [1:0] c_eval_slot  = VIDEO_SLOT - 2'd1;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_who_t          r_who;
  arb_who_t          w_who_sel;
  logic [1:0]        r_bus_cycle;
  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_nxt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [63:0]       r_rdata;

  logic w_eval;
  logic w_slot_end;
  logic w_disp_req;
  logic w_dma_forced;
  logic w_any_req;
  logic w_grant;

  assign w_eval       = clk_8_en && (r_bus_cycle == c_eval_slot);
  assign w_slot_end   = clk_8_en && (r_bus_cycle == VIDEO_SLOT);
  // Only the display owner's request is visible; the other is ignored.
  assign w_disp_req   = viking_en ? vik_req : shf_req;
  assign w_dma_forced = dma_req && (r_starve_cnt == c_max_starve);
  assign w_any_req    = w_disp_req || dma_req;
  assign w_grant      = w_eval && (r_state == ST_IDLE) && w_any_req;

  // Three-way priority select: display beats DMA unless DMA is starved.
  always_comb begin
    w_who_sel  = GNT_DMA;
    w_addr_sel = dma_addr;
    if (w_disp_req && !w_dma_forced) begin
      if (viking_en) begin
        w_who_sel  = GNT_VIK;
        w_addr_sel = vik_addr;
      end else begin
        w_who_sel  = GNT_SHF;
        w_addr_sel = shf_addr;
      end
    end
  end

  // Starvation count after a granting evaluation. An idle evaluation (no
  // request at all) never reaches here, so the count is left untouched then.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!dma_req || (w_who_sel == GNT_DMA)) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve_cnt < c_max_starve) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  // FSM next state and outputs.
  always_comb begin
    w_state_nxt = r_state;
    ram_read    = 1'b0;
    vik_ack     = 1'b0;
    shf_ack     = 1'b0;
    dma_ack     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        ram_read = 1'b1;
        if (w_slot_end) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        vik_ack     = (r_who == GNT_VIK);
        shf_ack     = (r_who == GNT_SHF);
        dma_ack     = (r_who == GNT_DMA);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_bus_cycle  <= 2'd0;
      r_starve_cnt <= 4'd0;
      r_who        <= GNT_VIK;
      r_ram_addr   <= '0;
      r_rdata      <= 64'd0;
    end else begin
      if (clk_8_en) begin
        r_bus_cycle <= r_bus_cycle + 2'd1;
      end
      // Grant and address are frozen here so requester changes during the
      // slot cannot disturb the access in flight.
      if (w_grant) begin
        r_who        <= w_who_sel;
        r_ram_addr   <= w_addr_sel;
        r_starve_cnt <= w_starve_nxt;
      end
      if ((r_state == ST_GRANT) && w_slot_end) begin
        r_rdata <= ram_data;
      end
    end
  end

  assign bus_cycle = r_bus_cycle;
  assign ram_addr  = r_ram_addr;
  assign rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_video_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_slot_arbiter
//  Description : Self-checking bench for video_slot_arbiter. A slot-level
//                reference model predicts every output after each pclk edge;
//                directed scenarios are followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_slot_arbiter;

  localparam int MAXS = 8;

  logic        pclk      = 1'b0;
  logic        reset     = 1'b0;
  logic        clk_8_en  = 1'b0;
  logic [1:0]  bus_cycle;
  logic        vik_req   = 1'b0;
  logic [22:0] vik_addr  = 23'd0;
  logic        shf_req   = 1'b0;
  logic [22:0] shf_addr  = 23'd0;
  logic        dma_req   = 1'b0;
  logic [22:0] dma_addr  = 23'd0;
  logic        viking_en = 1'b0;
  logic [22:0] ram_addr;
  logic        ram_read;
  logic [63:0] ram_data  = 64'd0;
  logic [63:0] rdata;
  logic        vik_ack, shf_ack, dma_ack;

  int total = 0;
  int bad   = 0;
  int phase = 0;

  // Reference model: slot index, whether a video access is in flight, who
  // owns it (1 vik, 2 shf, 3 dma), ack due this pclk, starvation count.
  int          m_slot = 0;
  int          m_busy = 0;
  int          m_who  = 0;
  int          m_ack  = 0;
  int          m_starve = 0;
  logic [22:0] m_addr  = 23'd0;
  logic [63:0] m_rdata = 64'd0;

  video_slot_arbiter #(.MAX_STARVE(MAXS)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .clk_8_en  (clk_8_en),
    .bus_cycle (bus_cycle),
    .vik_req   (vik_req),
    .vik_addr  (vik_addr),
    .shf_req   (shf_req),
    .shf_addr  (shf_addr),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .viking_en (viking_en),
    .ram_addr  (ram_addr),
    .ram_read  (ram_read),
    .ram_data  (ram_data),
    .rdata     (rdata),
    .vik_ack   (vik_ack),
    .shf_ack   (shf_ack),
    .dma_ack   (dma_ack)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_slot = 0; m_busy = 0; m_who = 0; m_ack = 0; m_starve = 0;
    m_addr = 23'd0; m_rdata = 64'd0;
  endtask

  // Effect of one pclk edge on the model, using the inputs held across it.
  task automatic model_edge();
    int disp;
    if (reset) begin
      model_clear();
      return;
    end
    m_ack = 0;
    if (clk_8_en) begin
      if (m_slot == 2 && m_busy != 0) begin
        m_rdata = ram_data;
        m_ack   = m_who;
        m_busy  = 0;
      end
      if (m_slot == 1) begin
        disp = viking_en ? int'(vik_req) : int'(shf_req);
        if (disp != 0 && !(dma_req && m_starve == MAXS)) begin
          m_who    = viking_en ? 1 : 2;
          m_addr   = viking_en ? vik_addr : shf_addr;
          m_busy   = 1;
          m_starve = dma_req ? ((m_starve < MAXS) ? m_starve + 1 : MAXS) : 0;
        end else if (dma_req) begin
          m_who    = 3;
          m_addr   = dma_addr;
          m_busy   = 1;
          m_starve = 0;
        end
      end
      m_slot = (m_slot + 1) % 4;
    end
  endtask

  task automatic check_outputs();
    chk("bus_cycle", 64'(bus_cycle), 64'(m_slot));
    chk("ram_read",  64'(ram_read),  64'(m_busy != 0));
    chk("ram_addr",  64'(ram_addr),  64'(m_addr));
    chk("rdata",     rdata,          m_rdata);
    chk("vik_ack",   64'(vik_ack),   64'(m_ack == 1));
    chk("shf_ack",   64'(shf_ack),   64'(m_ack == 2));
    chk("dma_ack",   64'(dma_ack),   64'(m_ack == 3));
  endtask

  task automatic tick();
    @(posedge pclk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive_en(input bit rnd);
    if (rnd) clk_8_en = ($urandom_range(0, 2) == 0);
    else     clk_8_en = ((phase % 4) == 3);
    phase++;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      drive_en(rnd);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_8_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int vik_cnt, dma_cnt, rd_cnt, ack_cnt, found;

    // Reset state, checked right after the asynchronous assertion.
    #3 reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    tick();
    tick();
    reset = 1'b0;

    // Viking owns the display and holds a request.
    viking_en = 1'b1;
    vik_req   = 1'b1;
    vik_addr  = 23'h600000;
    ram_data  = 64'h0123456789ABCDEF;
    vik_cnt   = 0;
    for (int i = 0; i < 48; i++) begin
      drive_en(1'b0);
      tick();
      if (vik_ack) vik_cnt++;
    end
    chk("s1_rdata", rdata, 64'h0123456789ABCDEF);
    chk("s1_some_acks", 64'(vik_cnt >= 2), 64'd1);

    // Viking and DMA both held: DMA must win the ninth evaluation.
    do_reset();
    dma_req  = 1'b1;
    dma_addr = 23'h012345;
    vik_cnt  = 0;
    dma_cnt  = 0;
    for (int i = 0; i < 200; i++) begin
      drive_en(1'b0);
      tick();
      if (vik_ack) vik_cnt++;
      if (dma_ack) begin
        if (dma_cnt == 0) begin
          chk("s2_vik_wins_before_dma", 64'(vik_cnt), 64'd8);
          chk("s2_dma_addr", 64'(ram_addr), 64'h012345);
        end
        dma_cnt++;
      end
    end
    chk("s2_dma_won", 64'(dma_cnt >= 1), 64'd1);
    chk("s2_vik_after_dma", 64'(vik_cnt > 8), 64'd1);

    // Shifter owns the display: a Viking request is ignored.
    do_reset();
    dma_req   = 1'b0;
    viking_en = 1'b0;
    vik_req   = 1'b1;
    shf_req   = 1'b0;
    rd_cnt    = 0;
    ack_cnt   = 0;
    for (int i = 0; i < 64; i++) begin
      drive_en(1'b0);
      tick();
      if (ram_read) rd_cnt++;
      if (vik_ack)  ack_cnt++;
    end
    chk("s3_no_read", 64'(rd_cnt), 64'd0);
    chk("s3_no_vik_ack", 64'(ack_cnt), 64'd0);

    // Request dropped and address changed while the slot is in flight.
    viking_en = 1'b1;
    vik_addr  = 23'h600000;
    found     = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      drive_en(1'b0);
      tick();
      if (m_busy != 0) found = 1;
    end
    chk("s4_granted", 64'(found), 64'd1);
    vik_req  = 1'b0;
    vik_addr = 23'h740000;
    ack_cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      drive_en(1'b0);
      tick();
      if (ram_read) chk("s4_addr_held", 64'(ram_addr), 64'h600000);
      if (vik_ack)  ack_cnt++;
    end
    chk("s4_ack_pulsed", 64'(ack_cnt), 64'd1);

    // Reset in the middle of a grant.
    vik_req = 1'b1;
    found   = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      drive_en(1'b0);
      tick();
      if (m_busy != 0) found = 1;
    end
    chk("s5_granted", 64'(found), 64'd1);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_outputs();
    tick();
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      drive_en(1'b0);
      tick();
      if (ram_read) begin
        found = 1;
        chk("s5_first_grant_slot", 64'(bus_cycle), 64'd2);
      end
    end
    chk("s5_grant_after_release", 64'(found), 64'd1);

    // Randomized traffic with an irregular bus strobe.
    for (int i = 0; i < 3000; i++) begin
      drive_en(1'b1);
      if ($urandom_range(0, 3) == 0) vik_req = 1'($urandom);
      if ($urandom_range(0, 3) == 0) shf_req = 1'($urandom);
      if ($urandom_range(0, 3) == 0) dma_req = 1'($urandom);
      if ($urandom_range(0, 40) == 0) viking_en = ~viking_en;
      vik_addr = 23'($urandom);
      shf_addr = 23'($urandom);
      dma_addr = 23'($urandom);
      ram_data = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
